lsu_mem_master: RTL

- Load/store initiator driving the data port (Port B) of the core's simulation memory.
- Accepts one load or store at a time from the execute stage and converts it into a single doubleword-aligned memory transaction with byte enables and lane-shifted write data.
- Returns sign- or zero-extended load data, or a store completion, to writeback over a valid/ready handshake.
- Detects misaligned accesses and reports them without issuing any memory transaction.

---
 rtl/lsu_mem_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_master.sv
// Load/store initiator for the data port of the simulation memory: one access at a time,
// doubleword-aligned transaction with byte enables, extended load data back to writeback.
module lsu_mem_master #(
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    input  logic [4:0]  req_rd_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic [4:0]  rsp_rd_o,
    output logic        rsp_misaligned_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [7:0]  mem_be_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i
);

    localparam int unsigned CNT_W  = 3;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TAG_W  = 5;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;

    logic               we_q, we_d;
    logic               uns_q, uns_d;
    logic [1:0]         size_q, size_d;
    logic [2:0]         off_q, off_d;
    logic [TAG_W-1:0]   rd_q, rd_d;

    logic               req_ready_d, rsp_valid_d, rsp_mis_d;
    logic [DATA_W-1:0]  rsp_rdata_d;
    logic [TAG_W-1:0]   rsp_rd_d;
    logic               mem_req_d, mem_we_d;
    logic [7:0]         mem_be_d;
    logic [DATA_W-1:0]  mem_addr_d, mem_wdata_d;

    logic               accept, misaligned, sample;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            default: return |off;
        endcase
    endfunction

    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'b00:   return 8'(8'h01 << off);
            2'b01:   return 8'(8'h03 << off);
            2'b10:   return 8'(8'h0F << off);
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [63:0] extract(input logic [63:0] rdata, input logic [1:0] size,
                                            input logic uns, input logic [2:0] off);
        logic [63:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   return uns ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
            2'b01:   return uns ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
            2'b10:   return uns ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
            default: return sh;
        endcase
    endfunction

    assign accept     = req_valid_i && req_ready_o;
    assign misaligned = is_misaligned(req_size_i, req_addr_i[2:0]);
    // Read data is captured at the end of ACCESS (no latency) or in the last WAIT cycle.
    assign sample     = ((state == ACCESS) && (RD_LATENCY == 0)) ||
                        ((state == WAIT) && (cnt == CNT_W'(RD_LATENCY - 1)));

    // State register; all outputs are registered from their next values here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            cnt              <= '0;
            we_q             <= 1'b0;
            uns_q            <= 1'b0;
            size_q           <= 2'b00;
            off_q            <= 3'b000;
            rd_q             <= '0;
            req_ready_o      <= 1'b1;
            rsp_valid_o      <= 1'b0;
            rsp_rdata_o      <= '0;
            rsp_rd_o         <= '0;
            rsp_misaligned_o <= 1'b0;
            mem_req_o        <= 1'b0;
            mem_we_o         <= 1'b0;
            mem_be_o         <= '0;
            mem_addr_o       <= '0;
            mem_wdata_o      <= '0;
        end else begin
            state            <= state_next;
            cnt              <= cnt_next;
            we_q             <= we_d;
            uns_q            <= uns_d;
            size_q           <= size_d;
            off_q            <= off_d;
            rd_q             <= rd_d;
            req_ready_o      <= req_ready_d;
            rsp_valid_o      <= rsp_valid_d;
            rsp_rdata_o      <= rsp_rdata_d;
            rsp_rd_o         <= rsp_rd_d;
            rsp_misaligned_o <= rsp_mis_d;
            mem_req_o        <= mem_req_d;
            mem_we_o         <= mem_we_d;
            mem_be_o         <= mem_be_d;
            mem_addr_o       <= mem_addr_d;
            mem_wdata_o      <= mem_wdata_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) state_next = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                cnt_next   = '0;
                state_next = (RD_LATENCY == 0) ? RESP : WAIT;
            end
            WAIT: begin
                if (sample) state_next = RESP;
                else        cnt_next   = cnt + CNT_W'(1);
            end
            RESP: begin
                if (rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output next values: strobes follow the next state, payload registers hold unless loaded.
    always_comb begin
        req_ready_d = (state_next == IDLE);
        rsp_valid_d = (state_next == RESP);
        mem_req_d   = (state_next == ACCESS);
        mem_we_d    = 1'b0;
        mem_be_d    = mem_be_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        rsp_rdata_d = rsp_rdata_o;
        rsp_rd_d    = rsp_rd_o;
        rsp_mis_d   = rsp_misaligned_o;
        we_d        = we_q;
        uns_d       = uns_q;
        size_d      = size_q;
        off_d       = off_q;
        rd_d        = rd_q;
        if (accept) begin
            we_d   = req_we_i;
            uns_d  = req_unsigned_i;
            size_d = req_size_i;
            off_d  = req_addr_i[2:0];
            rd_d   = req_rd_i;
            if (misaligned) begin
                rsp_rdata_d = '0;
                rsp_mis_d   = 1'b1;
                rsp_rd_d    = req_rd_i;
            end else begin
                mem_we_d    = req_we_i;
                mem_be_d    = lane_mask(req_size_i, req_addr_i[2:0]);
                mem_addr_d  = {req_addr_i[63:3], 3'b000};
                mem_wdata_d = req_wdata_i << {req_addr_i[2:0], 3'b000};
            end
        end
        if (sample) begin
            rsp_rdata_d = we_q ? '0 : extract(mem_rdata_i, size_q, uns_q, off_q);
            rsp_mis_d   = 1'b0;
            rsp_rd_d    = rd_q;
        end
    end

endmodule
